// File: rtl/guvm_data_mem_responder.sv
// Data-memory responder: req/gnt/rvalid handshake, gap-throttled grants, byte-enabled word array
// and a fixed-latency response pipeline. Define GUVM_MEM_ERR_EN to add out-of-range error responses.
module guvm_data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned GNT_GAP     = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o
`ifdef GUVM_MEM_ERR_EN
    ,
    output logic        data_err_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [2:0]    gap_cnt;
    logic          handshake;
    logic          addr_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   load_data;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [LATENCY-1:0] valid_q;
    logic [31:0]        rdata_q [LATENCY];
`ifdef GUVM_MEM_ERR_EN
    logic [LATENCY-1:0] err_q;
`endif

    // Byte-offset bits never select anything; upper bits matter only for range checking.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_addr_i[1:0], data_addr_i[31:AW+2]};

    assign word_idx   = data_addr_i[2 +: AW];
    assign handshake  = data_req_i && (gap_cnt == 3'd0);
    assign data_gnt_o = handshake;

`ifdef GUVM_MEM_ERR_EN
    assign addr_err = |data_addr_i[31:AW+2];
`else
    assign addr_err = 1'b0;
`endif

    // Loads see the array as left by earlier edges; stores and loads never share a handshake.
    assign load_data = (data_we_i || addr_err) ? 32'd0 : mem[word_idx];

    // NOTE: the array is deliberately left out of reset so contents survive it; gating the
    // write with rst_ni keeps a store from landing on an edge where reset is still held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && handshake && data_we_i && !addr_err) begin
            for (int k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every stage shifts on the same
    // edge without one stage observing another stage's freshly written value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap_cnt <= 3'd0;
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rdata_q[i] <= 32'd0;
            end
`ifdef GUVM_MEM_ERR_EN
            err_q <= '0;
`endif
        end else begin
            if (handshake) begin
                gap_cnt <= 3'(GNT_GAP);
            end else if (gap_cnt != 3'd0) begin
                gap_cnt <= gap_cnt - 3'd1;
            end

            valid_q[0] <= handshake;
            rdata_q[0] <= handshake ? load_data : 32'd0;
`ifdef GUVM_MEM_ERR_EN
            err_q[0]   <= handshake && addr_err;
`endif
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
`ifdef GUVM_MEM_ERR_EN
                err_q[i]   <= err_q[i-1];
`endif
            end
        end
    end

    assign data_rvalid_o = valid_q[LATENCY-1];
    assign data_rdata_o  = rdata_q[LATENCY-1];
`ifdef GUVM_MEM_ERR_EN
    assign data_err_o    = err_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_guvm_data_mem_responder.sv
// Directed bench for guvm_data_mem_responder: three instances (latency 1, latency 3, latency 2 with
// grant gap 2) share one stimulus bus; each step checks the instance it targets.
module tb_guvm_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
    logic [31:0] rd_a, rd_b, rd_c;
`ifdef GUVM_MEM_ERR_EN
    logic        err_a, err_b, err_c;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    guvm_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .GNT_GAP(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt_a), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rv_a), .data_rdata_o(rd_a)
`ifdef GUVM_MEM_ERR_EN
        , .data_err_o(err_a)
`endif
    );

    guvm_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3), .GNT_GAP(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt_b), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rv_b), .data_rdata_o(rd_b)
`ifdef GUVM_MEM_ERR_EN
        , .data_err_o(err_b)
`endif
    );

    guvm_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .GNT_GAP(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt_c), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rv_c), .data_rdata_o(rd_c)
`ifdef GUVM_MEM_ERR_EN
        , .data_err_o(err_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge, where registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        u_a.mem[0] = 32'h0123_4567;
        u_a.mem[3] = 32'hDEAD_BEEF;
        u_a.mem[4] = 32'h1122_3344;
        for (int i = 0; i < 4; i++) u_b.mem[i] = 32'(i);
        u_c.mem[5] = 32'hCAFE_F00D;

        // Reset held for 10 cycles
        repeat (10) tick();
        check("rst_rvalid_a", {31'd0, rv_a}, 32'd0);
        check("rst_rdata_a", rd_a, 32'd0);
        check("rst_rvalid_b", {31'd0, rv_b}, 32'd0);
        check("rst_rdata_c", rd_c, 32'd0);
        drive(1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
        check("rst_gnt_follows_req_hi", {31'd0, gnt_a}, 32'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("rst_gnt_follows_req_lo", {31'd0, gnt_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Preloaded word 3 survives reset
        drive(1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
        check("load3_gnt", {31'd0, gnt_a}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("load3_rvalid", {31'd0, rv_a}, 32'd1);
        check("load3_rdata", rd_a, 32'hDEAD_BEEF);
        tick();
        check("load3_rvalid_pulse", {31'd0, rv_a}, 32'd0);
        check("load3_rdata_idle", rd_a, 32'd0);

        // Byte-enabled store then read-after-write on the next grant
        drive(1'b1, 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD);
        tick();
        check("store_rvalid", {31'd0, rv_a}, 32'd1);
        check("store_rdata_zero", rd_a, 32'd0);
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        tick();
        check("raw_rvalid", {31'd0, rv_a}, 32'd1);
        check("raw_rdata", rd_a, 32'h11BB_33DD);
        drive(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
        tick();
        check("be0_store_rvalid", {31'd0, rv_a}, 32'd1);
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("be0_store_no_write", rd_a, 32'h11BB_33DD);
        tick();
        check("be0_rvalid_pulse", {31'd0, rv_a}, 32'd0);
        repeat (4) tick();

        // Latency 3: four back-to-back loads of words 0..3
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                drive(1'b1, 1'b0, 4'h0, 32'(4 * i), 32'h0);
                check($sformatf("b2b_gnt_%0d", i), {31'd0, gnt_b}, 32'd1);
            end else begin
                drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
            tick();
            check($sformatf("b2b_rvalid_%0d", i), {31'd0, rv_b}, (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
            check($sformatf("b2b_rdata_%0d", i), rd_b, (i >= 2 && i <= 5) ? 32'(i - 2) : 32'd0);
        end
        repeat (3) tick();

        // Gap 2: request held 9 cycles, grants in cycles 0, 3, 6
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
            check($sformatf("gap_gnt_%0d", i), {31'd0, gnt_c}, (i % 3 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();

        // Reset pulse one cycle after a load grant drops that response
        drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        check("flush_gnt", {31'd0, gnt_c}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("flush_rvalid_in_reset", {31'd0, rv_c}, 32'd0);
        tick();
        check("flush_rvalid_dropped", {31'd0, rv_c}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("flush_rvalid_after", {31'd0, rv_c}, 32'd0);

        drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        check("post_rst_gnt", {31'd0, gnt_c}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("post_rst_rvalid_early", {31'd0, rv_c}, 32'd0);
        tick();
        check("post_rst_rvalid", {31'd0, rv_c}, 32'd1);
        check("post_rst_rdata", rd_c, 32'hCAFE_F00D);
        tick();
        check("post_rst_rvalid_pulse", {31'd0, rv_c}, 32'd0);

        // Stored word persists across the second reset
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("persist_rdata", rd_a, 32'h11BB_33DD);
        tick();

        // Out-of-range address 0x400: error response, or alias of word 0
        drive(1'b1, 1'b1, 4'hF, 32'h400, 32'h5A5A_5A5A);
        tick();
        check("oor_store_rvalid", {31'd0, rv_a}, 32'd1);
`ifdef GUVM_MEM_ERR_EN
        check("oor_store_err", {31'd0, err_a}, 32'd1);
`endif
        drive(1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
        tick();
        check("oor_load_rvalid", {31'd0, rv_a}, 32'd1);
`ifdef GUVM_MEM_ERR_EN
        check("oor_load_err", {31'd0, err_a}, 32'd1);
        check("oor_load_rdata", rd_a, 32'd0);
`else
        check("alias_load_rdata", rd_a, 32'h5A5A_5A5A);
`endif
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
`ifdef GUVM_MEM_ERR_EN
        check("word0_untouched", rd_a, 32'h0123_4567);
        check("word0_err_clear", {31'd0, err_a}, 32'd0);
`else
        check("word0_aliased", rd_a, 32'h5A5A_5A5A);
`endif
        tick();
        check("final_idle_rvalid", {31'd0, rv_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
